// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl
// Sequencing controller for a WIDTH-bit down-counter. It loads a start value,
// paces decrements through a programmable prescaler, and supports pause, stop
// and one-shot or periodic (auto-reload) operation. It emits a one-cycle tick
// after every decrement and a done pulse at each terminal count.
module down_counter_ctrl #(
    parameter int WIDTH = 3,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic             paused
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] reload_val_r;
    logic [WIDTH-1:0] reload_val_nxt_s;
    logic [PRE_W-1:0] pre_cnt_r;
    logic [PRE_W-1:0] pre_cnt_nxt_s;
    logic [PRE_W-1:0] pre_reload_r;
    logic [PRE_W-1:0] pre_reload_nxt_s;
    logic             mode_r;
    logic             mode_nxt_s;
    logic             dec_s;

    logic             tick_r;
    logic             done_r;
    logic             busy_r;
    logic             paused_r;
    logic             tick_nxt_s;
    logic             done_nxt_s;
    logic             busy_nxt_s;
    logic             paused_nxt_s;

    // State, datapath and output registers; rst clears everything in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            count_r      <= CNT_ZERO;
            reload_val_r <= CNT_ZERO;
            pre_cnt_r    <= PRE_ZERO;
            pre_reload_r <= PRE_ZERO;
            mode_r       <= 1'b0;
            tick_r       <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            paused_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            reload_val_r <= reload_val_nxt_s;
            pre_cnt_r    <= pre_cnt_nxt_s;
            pre_reload_r <= pre_reload_nxt_s;
            mode_r       <= mode_nxt_s;
            tick_r       <= tick_nxt_s;
            done_r       <= done_nxt_s;
            busy_r       <= busy_nxt_s;
            paused_r     <= paused_nxt_s;
        end
    end

    // Next-state and datapath update: stop beats pause beats counting.
    // A PAUSE cycle that sees pause low performs a normal RUN step, so the
    // frozen prescaler phase resumes on the release edge without a lost cycle.
    always_comb begin
        state_nxt_s      = state_r;
        count_nxt_s      = count_r;
        reload_val_nxt_s = reload_val_r;
        pre_cnt_nxt_s    = pre_cnt_r;
        pre_reload_nxt_s = pre_reload_r;
        mode_nxt_s       = mode_r;
        dec_s            = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    count_nxt_s      = load_val;
                    reload_val_nxt_s = load_val;
                    pre_cnt_nxt_s    = prescale;
                    pre_reload_nxt_s = prescale;
                    mode_nxt_s       = periodic;
                    if (load_val != CNT_ZERO) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (pause) begin
                    state_nxt_s = ST_PAUSE;
                end else if (pre_cnt_r != PRE_ZERO) begin
                    pre_cnt_nxt_s = pre_cnt_r - PRE_ONE;
                    state_nxt_s   = ST_RUN;
                end else if (count_r != CNT_ZERO) begin
                    pre_cnt_nxt_s = pre_reload_r;
                    count_nxt_s   = count_r - CNT_ONE;
                    dec_s         = 1'b1;
                    if (count_r == CNT_ONE) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    // Count already at zero: never wrap, just terminate.
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (mode_r) begin
                    count_nxt_s   = reload_val_r;
                    pre_cnt_nxt_s = pre_reload_r;
                    if (reload_val_r != CNT_ZERO) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        tick_nxt_s   = dec_s;
        done_nxt_s   = (state_nxt_s == ST_DONE);
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        paused_nxt_s = (state_nxt_s == ST_PAUSE);
    end

    assign count  = count_r;
    assign tick   = tick_r;
    assign done   = done_r;
    assign busy   = busy_r;
    assign paused = paused_r;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed testbench for down_counter_ctrl. Each task drives one scenario and
// compares the packed output vector {count,tick,done,busy,paused} with
// hand-derived expectations after every clock edge.
module tb_down_counter_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic       periodic;
    logic [2:0] load_val;
    logic [7:0] prescale;
    logic [2:0] count;
    logic       tick;
    logic       done;
    logic       busy;
    logic       paused;

    int         n_checks;
    int         n_fail;
    logic [6:0] obs;
    logic [6:0] exp_v;

    down_counter_ctrl #(.WIDTH(3), .PRE_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .load_val (load_val),
        .prescale (prescale),
        .count    (count),
        .tick     (tick),
        .done     (done),
        .busy     (busy),
        .paused   (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; outputs are then sampled 1 time unit later.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0;
        load_val = 3'd0; prescale = 8'd0;
        cyc(2);
        rst = 1'b0;
        for (int t = 0; t < 10; t++) begin
            cyc(1);
            obs = {count, tick, done, busy, paused};
            exp_v = 7'b0;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_oneshot_p0();
        load_val = 3'd5; prescale = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int t = 0; t <= 7; t++) begin
            if (t > 0) cyc(1);
            if (t == 0)      exp_v = {3'd5, 1'b0, 1'b0, 1'b1, 1'b0};
            else if (t < 5)  exp_v = {3'(5 - t), 1'b1, 1'b0, 1'b1, 1'b0};
            else if (t == 5) exp_v = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
            else             exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
            obs = {count, tick, done, busy, paused};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL oneshot_p0 t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_periodic();
        int ticks;
        int dones;
        int u;
        ticks = 0;
        dones = 0;
        load_val = 3'd3; prescale = 8'd2; periodic = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        // Changing the sampled inputs mid-run must have no effect.
        load_val = 3'd6; prescale = 8'd0; periodic = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            cyc(1);
            u = t % 10;
            exp_v = {(u == 0) ? 3'd3 : 3'(3 - u / 3), (u != 0 && u % 3 == 0),
                     (u == 9), 1'b1, 1'b0};
            obs = {count, tick, done, busy, paused};
            ticks += int'(tick);
            dones += int'(done);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL periodic t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
        n_checks++;
        if (ticks != 9 || dones != 3) begin
            n_fail++;
            $display("FAIL periodic_pulses: got ticks=%0d dones=%0d required 9 and 3", ticks, dones);
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        obs = {count, tick, done, busy, paused};
        exp_v = {3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL periodic_stop: got %b required %b", obs, exp_v);
        end
    endtask

    task automatic test_pause();
        int r;
        load_val = 3'd7; prescale = 8'd1; periodic = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            pause = (t >= 8 && t <= 12);
            cyc(1);
            pause = 1'b0;
            if (t >= 8 && t <= 12) begin
                exp_v = {3'd4, 1'b0, 1'b0, 1'b1, 1'b1};
            end else begin
                r = (t < 8) ? t : t - 5;
                if (r == 15) exp_v = 7'b0;
                else exp_v = {3'(7 - r / 2), (r % 2 == 0), (r == 14), 1'b1, 1'b0};
            end
            obs = {count, tick, done, busy, paused};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL pause t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        // stop together with pause in RUN goes to IDLE with count frozen.
        load_val = 3'd6; prescale = 8'd0; periodic = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        stop = 1'b1; pause = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc(1);
            stop = 1'b0; pause = 1'b0;
            obs = {count, tick, done, busy, paused};
            exp_v = {3'd5, 1'b0, 1'b0, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stop_pause t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
        // start with a zero load gives a single done pulse, then IDLE.
        load_val = 3'd0; start = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc(1);
            start = 1'b0;
            exp_v = (t == 0) ? {3'd0, 1'b0, 1'b1, 1'b1, 1'b0} : 7'b0;
            obs = {count, tick, done, busy, paused};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL load_zero t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
        // start held during RUN with a new load value is ignored.
        load_val = 3'd4; start = 1'b1;
        cyc(1);
        load_val = 3'd7;
        for (int t = 1; t <= 5; t++) begin
            cyc(1);
            if (t < 4)       exp_v = {3'(4 - t), 1'b1, 1'b0, 1'b1, 1'b0};
            else if (t == 4) exp_v = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
            else             exp_v = 7'b0;
            if (t == 3) start = 1'b0;
            obs = {count, tick, done, busy, paused};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL start_in_run t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
        // start and stop together in IDLE latch nothing.
        load_val = 3'd5; start = 1'b1; stop = 1'b1;
        cyc(2);
        start = 1'b0; stop = 1'b0;
        obs = {count, tick, done, busy, paused};
        exp_v = 7'b0;
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL start_stop_idle: got %b required %b", obs, exp_v);
        end
    endtask

    task automatic test_periodic_zero();
        load_val = 3'd0; prescale = 8'd3; periodic = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) cyc(1);
            if (t == 5) stop = 1'b1;
            obs = {count, tick, done, busy, paused};
            exp_v = {3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL periodic_zero t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
        cyc(1);
        stop = 1'b0;
        obs = {count, tick, done, busy, paused};
        exp_v = 7'b0;
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL periodic_zero_stop: got %b required %b", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        load_val = 3'd3; prescale = 8'd1; periodic = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        obs = {count, tick, done, busy, paused};
        exp_v = {3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got %b required %b", obs, exp_v);
        end
        rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc(1);
            rst = 1'b0;
            obs = {count, tick, done, busy, paused};
            exp_v = 7'b0;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
        load_val = 3'd1; prescale = 8'd1; periodic = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            cyc(1);
            if (t == 1)      exp_v = {3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
            else if (t == 2) exp_v = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
            else             exp_v = 7'b0;
            obs = {count, tick, done, busy, paused};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL fresh_start t=%0d: got %b required %b", t, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_oneshot_p0();
        test_periodic();
        test_pause();
        test_simultaneous();
        test_periodic_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
